mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 76 +++++++
 tb/tb_mem_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with EX/MEM register, byte-addressable data memory and MEM/WB register.
module mem_stage #(
  parameter int DM_AW       = 10,
  parameter int PC_LINK_OFF = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluout_ex,
  input  logic [31:0] tr_b_ex,
  input  logic [4:0]  a3_ex,
  input  logic [31:0] pc_ex,
  input  logic        MemWrite_ex,
  input  logic [1:0]  MemSize_ex,
  input  logic        MemSign_ex,
  input  logic        RegWrite_ex,
  input  logic [1:0]  MemtoReg_ex,
  output logic [31:0] aluout_mem,
  output logic [4:0]  a3_mem,
  output logic        RegWrite_mem,
  output logic [31:0] wd_wb,
  output logic [4:0]  a3_wb,
  output logic        RegWrite_wb
);
  logic [31:0] tr_b_mem, pc_mem, rd, ld, wr_word, wb_sel;
  logic        mem_write, mem_sign;
  logic [1:0]  mem_size, mem_to_reg;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [DM_AW-1:0] idx;
  logic [31:0] dm [2**DM_AW];
  assign idx     = aluout_mem[DM_AW+1:2];
  assign rd      = dm[idx];
  assign rd_byte = rd[{aluout_mem[1:0], 3'b000} +: 8];
  assign rd_half = aluout_mem[1] ? rd[31:16] : rd[15:0];
  assign ld = mem_size == 2'b01 ? {{16{mem_sign & rd_half[15]}}, rd_half} :
              mem_size == 2'b10 ? {{24{mem_sign & rd_byte[7]}}, rd_byte} : rd;
  assign wb_sel = mem_to_reg == 2'b01 ? ld :
                  mem_to_reg == 2'b10 ? pc_mem + 32'(PC_LINK_OFF) : aluout_mem;
  // Sub-word stores merge into the current word read combinationally.
  always_comb begin
    wr_word = mem_size == 2'b01 ? (aluout_mem[1] ? {tr_b_mem[15:0], rd[15:0]} : {rd[31:16], tr_b_mem[15:0]}) : tr_b_mem;
    if (mem_size == 2'b10) wr_word = rd;
    if (mem_size == 2'b10) wr_word[{aluout_mem[1:0], 3'b000} +: 8] = tr_b_mem[7:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      aluout_mem   <= '0;
      tr_b_mem     <= '0;
      a3_mem       <= '0;
      pc_mem       <= '0;
      mem_write    <= 1'b0;
      mem_size     <= '0;
      mem_sign     <= 1'b0;
      RegWrite_mem <= 1'b0;
      mem_to_reg   <= '0;
      wd_wb        <= '0;
      a3_wb        <= '0;
      RegWrite_wb  <= 1'b0;
      for (int i = 0; i < 2**DM_AW; i++) dm[i] <= '0;
    end else begin
      aluout_mem   <= aluout_ex;
      tr_b_mem     <= tr_b_ex;
      a3_mem       <= a3_ex;
      pc_mem       <= pc_ex;
      mem_write    <= MemWrite_ex;
      mem_size     <= MemSize_ex;
      mem_sign     <= MemSign_ex;
      RegWrite_mem <= RegWrite_ex;
      mem_to_reg   <= MemtoReg_ex;
      wd_wb        <= wb_sel;
      a3_wb        <= a3_mem;
      RegWrite_wb  <= RegWrite_mem && a3_mem != 5'd0;
      if (mem_write) dm[idx] <= wr_word;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage write-back results and MEM-stage outputs.
module tb_mem_stage;
  logic        clk = 0, reset = 1;
  logic [31:0] aluout_ex = 0, tr_b_ex = 0, pc_ex = 0;
  logic [4:0]  a3_ex = 0;
  logic        MemWrite_ex = 0, MemSign_ex = 0, RegWrite_ex = 0;
  logic [1:0]  MemSize_ex = 0, MemtoReg_ex = 0;
  logic [31:0] aluout_mem, wd_wb;
  logic [4:0]  a3_mem, a3_wb;
  logic        RegWrite_mem, RegWrite_wb;
  int tests = 0, fails = 0;
  logic chk_in = 0, p1 = 0, p2 = 0;
  logic [37:0] sb [$];

  mem_stage dut (
    .clk(clk), .reset(reset), .aluout_ex(aluout_ex), .tr_b_ex(tr_b_ex), .a3_ex(a3_ex),
    .pc_ex(pc_ex), .MemWrite_ex(MemWrite_ex), .MemSize_ex(MemSize_ex), .MemSign_ex(MemSign_ex),
    .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex), .aluout_mem(aluout_mem),
    .a3_mem(a3_mem), .RegWrite_mem(RegWrite_mem), .wd_wb(wd_wb), .a3_wb(a3_wb),
    .RegWrite_wb(RegWrite_wb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= reset ? 1'b0 : chk_in;
    p2 <= reset ? 1'b0 : p1;
  end

  always @(negedge clk) if (p2) begin
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_underflow: result with no expectation");
    end else begin
      logic [37:0] e;
      e = sb.pop_front();
      if ({wd_wb, a3_wb, RegWrite_wb} !== e) begin
        fails++;
        $display("FAIL wb_result: got wd=%h a3=%0d rw=%b, want wd=%h a3=%0d rw=%b",
                 wd_wb, a3_wb, RegWrite_wb, e[37:6], e[5:1], e[0]);
      end
    end
  end

  task automatic op(input logic [31:0] alu, trb, pc, input logic [4:0] a3, input logic w,
                    input logic [1:0] sz, input logic sg, rw, input logic [1:0] m2r,
                    input logic chk, input logic [31:0] exp_wd, input logic exp_rw);
    aluout_ex = alu; tr_b_ex = trb; pc_ex = pc; a3_ex = a3; MemWrite_ex = w;
    MemSize_ex = sz; MemSign_ex = sg; RegWrite_ex = rw; MemtoReg_ex = m2r; chk_in = chk;
    if (chk) sb.push_back({exp_wd, a3, exp_rw});
    @(negedge clk);
  endtask

  task automatic st(input logic [31:0] addr, data, input logic [1:0] sz);
    op(addr, data, 0, 0, 1, sz, 0, 0, 2'b00, 1, addr, 0);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [4:0] a3, input logic [1:0] sz,
                    input logic sg, input logic [31:0] exp_wd);
    op(addr, 0, 0, a3, 0, sz, sg, 1, 2'b01, 1, exp_wd, a3 != 0);
  endtask

  task automatic bubble();
    op(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({aluout_mem, a3_mem, RegWrite_mem, wd_wb, a3_wb, RegWrite_wb} !== '0) begin
      fails++;
      $display("FAIL %s: got alu_mem=%h a3_mem=%0d rw_mem=%b wd=%h a3_wb=%0d rw_wb=%b, want all 0",
               name, aluout_mem, a3_mem, RegWrite_mem, wd_wb, a3_wb, RegWrite_wb);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    bubble(); bubble();
    check_zero("power_on_reset");
    reset = 0;
    op(32'h10, 32'h12345678, 32'h100, 5'd3, 1, 2'b00, 0, 1, 2'b00, 0, 0, 0);
    reset = 1;
    op(32'h10, 32'hCAFEBABE, 32'h104, 5'd5, 1, 2'b00, 0, 1, 2'b00, 0, 0, 0);
    reset = 0;
    check_zero("mid_op_reset");
    ld(32'h10, 5'd9, 2'b00, 0, 32'h0);
  endtask

  task automatic test_word();
    st(32'h20, 32'hDEADBEEF, 2'b00);
    ld(32'h20, 5'd8, 2'b00, 0, 32'hDEADBEEF);
    tests++;
    if (aluout_mem !== 32'h20 || a3_mem !== 5'd8 || RegWrite_mem !== 1'b1) begin
      fails++;
      $display("FAIL lw_mem_stage: got alu=%h a3=%0d rw=%b, want 00000020 8 1", aluout_mem, a3_mem, RegWrite_mem);
    end
  endtask

  task automatic test_byte();
    st(32'h21, 32'hFFFFFF5A, 2'b10);
    ld(32'h21, 5'd9, 2'b10, 1, 32'h0000005A);
    ld(32'h20, 5'd10, 2'b00, 1, 32'hDEAD5AEF);
    ld(32'h23, 5'd11, 2'b10, 0, 32'h000000DE);
    ld(32'h23, 5'd12, 2'b10, 1, 32'hFFFFFFDE);
    ld(32'h20, 5'd13, 2'b10, 1, 32'hFFFFFFEF);
  endtask

  task automatic test_half();
    st(32'h40, 32'h00001234, 2'b00);
    st(32'h42, 32'hABCD8001, 2'b01);
    ld(32'h40, 5'd14, 2'b00, 0, 32'h80011234);
    ld(32'h42, 5'd15, 2'b01, 1, 32'hFFFF8001);
    ld(32'h42, 5'd16, 2'b01, 0, 32'h00008001);
    ld(32'h41, 5'd17, 2'b01, 1, 32'h00001234);
    st(32'h44, 32'h00000000, 2'b11);
    st(32'h45, 32'h000000C3, 2'b10);
    ld(32'h44, 5'd18, 2'b11, 1, 32'h0000C300);
  endtask

  task automatic test_link_zero();
    op(32'h77, 0, 32'h00003000, 5'd31, 0, 0, 0, 1, 2'b10, 1, 32'h00003008, 1);
    op(32'h55, 0, 32'hFFFFFFFC, 5'd31, 0, 0, 0, 1, 2'b10, 1, 32'h00000004, 1);
    op(32'h99, 0, 32'h0, 5'd7, 0, 0, 0, 1, 2'b11, 1, 32'h99, 1);
    op(32'hABCD, 0, 0, 5'd0, 0, 0, 0, 1, 2'b00, 1, 32'hABCD, 0);
    tests++;
    if (RegWrite_mem !== 1'b1 || a3_mem !== 5'd0 || aluout_mem !== 32'hABCD) begin
      fails++;
      $display("FAIL zero_reg_mem: got rw=%b a3=%0d alu=%h, want 1 0 0000abcd", RegWrite_mem, a3_mem, aluout_mem);
    end
    op(32'h24, 32'h13572468, 0, 5'd6, 1, 2'b00, 0, 1, 2'b00, 1, 32'h24, 1);
    ld(32'h24, 5'd6, 2'b00, 0, 32'h13572468);
  endtask

  task automatic test_wrap();
    st(32'h1000, 32'h11111111, 2'b00);
    ld(32'h0, 5'd20, 2'b00, 0, 32'h11111111);
    ld(32'hFFFF_F000, 5'd21, 2'b00, 0, 32'h11111111);
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      st(32'h200 + 32'(4 * i), vals[i], 2'b00);
    end
    for (int i = 7; i >= 0; i--) ld(32'h200 + 32'(4 * i), 5'(i + 1), 2'b00, 0, vals[i]);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_link_zero();
    test_wrap();
    test_back_to_back();
    bubble(); bubble(); bubble();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
